// File: rtl/mbist_pkg.sv
// Shared types and the March element table for the MBIST engine.
// elem_info() is the single place that encodes March C- and MATS+.
package mbist_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
  typedef enum logic [1:0] {W0, W1, R0, R1} op_e;
  typedef enum logic {UP, DN} dir_e;
  typedef enum logic {MARCH_CM, MATS_P} algo_e;

  typedef struct packed {
    logic [1:0] num_ops;
    op_e [0:1]  op;
    dir_e       dir;
    logic       is_last;
  } elem_info_t;

  function automatic elem_info_t elem_info(algo_e algo, logic [2:0] elem);
    elem_info_t ei;
    ei.num_ops = 2'd2;
    ei.op[0]   = R0;
    ei.op[1]   = W1;
    ei.dir     = UP;
    ei.is_last = 1'b0;
    if (algo == MARCH_CM) begin
      case (elem)
        3'd0: begin ei.num_ops = 2'd1; ei.op[0] = W0; ei.op[1] = W0; end
        3'd1: begin ei.op[0] = R0; ei.op[1] = W1; end
        3'd2: begin ei.op[0] = R1; ei.op[1] = W0; end
        3'd3: begin ei.op[0] = R0; ei.op[1] = W1; ei.dir = DN; end
        3'd4: begin ei.op[0] = R1; ei.op[1] = W0; ei.dir = DN; end
        3'd5: begin ei.num_ops = 2'd1; ei.op[0] = R0; ei.op[1] = R0; ei.is_last = 1'b1; end
        default: begin ei.num_ops = 2'd1; ei.op[0] = W0; ei.op[1] = W0; ei.is_last = 1'b1; end
      endcase
    end else begin
      case (elem)
        3'd0: begin ei.num_ops = 2'd1; ei.op[0] = W0; ei.op[1] = W0; end
        3'd1: begin ei.op[0] = R0; ei.op[1] = W1; end
        3'd2: begin ei.op[0] = R1; ei.op[1] = W0; ei.dir = DN; ei.is_last = 1'b1; end
        default: begin ei.num_ops = 2'd1; ei.op[0] = W0; ei.op[1] = W0; ei.is_last = 1'b1; end
      endcase
    end
    return ei;
  endfunction

  function automatic dir_e first_dir(algo_e algo, logic [2:0] elem);
    elem_info_t ei;
    ei = elem_info(algo, elem);
    return ei.dir;
  endfunction

endpackage

// File: rtl/mbist_addr_gen.sv
// Up/down address counter for one March element: load-first, step, and a
// last-address flag so element boundaries never rely on counter wrap.
module mbist_addr_gen
  import mbist_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              load_dir,
  input  logic              step,
  input  logic              dir,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr <= '0;
    end else if (load) begin
      addr <= (dir_e'(load_dir) == DN) ? '1 : '0;
    end else if (step) begin
      addr <= (dir_e'(dir) == DN) ? addr - ADDR_W'(1) : addr + ADDR_W'(1);
    end
  end

  assign last = (dir_e'(dir) == DN) ? (addr == '0) : (addr == '1);

endmodule

// File: rtl/mbist_march_engine.sv
// March C- / MATS+ BIST engine for a single-port SRAM with 1-cycle read latency.
// Issues one op per cycle, compares reads on the fly, captures the first failure.
module mbist_march_engine
  import mbist_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              algo_sel,
  input  logic [DATA_W-1:0] bg,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              test_mode,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  output logic [DATA_W-1:0] fail_syn,
  output logic [CNT_W-1:0]  fail_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  state_e            state, state_n;
  algo_e             algo_q;
  logic [DATA_W-1:0] bg_q;
  logic [2:0]        elem_q;
  logic              op_q, drain_q;
  elem_info_t        cur_info;
  op_e               cur_op;
  logic              last_op, cur_is_write, run, abort_hit;
  logic [DATA_W-1:0] pattern;
  logic [ADDR_W-1:0] addr;
  logic              addr_last;
  logic              launch, ag_load, ag_step, elem_inc, op_set, op_clr;
  dir_e              ag_load_dir;
  logic [DATA_W-1:0] exp_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [2:0]        elem_p1;
  logic              vld_p1, mismatch;

  assign cur_info     = elem_info(algo_q, elem_q);
  assign cur_op       = op_q ? cur_info.op[1] : cur_info.op[0];
  assign last_op      = (cur_info.num_ops == 2'd1) || op_q;
  assign cur_is_write = (cur_op == W0) || (cur_op == W1);
  assign pattern      = ((cur_op == W1) || (cur_op == R1)) ? ~bg_q : bg_q;
  assign run          = (state == RUN);
  assign busy         = (state == RUN) || (state == DRAIN);
  assign abort_hit    = abort && busy;

  mbist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (ag_load),
    .load_dir (ag_load_dir),
    .step     (ag_step),
    .dir      (cur_info.dir),
    .addr     (addr),
    .last     (addr_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n     = state;
    launch      = 1'b0;
    ag_load     = 1'b0;
    ag_load_dir = UP;
    ag_step     = 1'b0;
    elem_inc    = 1'b0;
    op_set      = 1'b0;
    op_clr      = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = RUN;
          launch  = 1'b1;
          ag_load = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_n = IDLE;
        end else if (!last_op) begin
          op_set = 1'b1;
        end else begin
          op_clr = 1'b1;
          if (!addr_last) begin
            ag_step = 1'b1;
          end else if (cur_info.is_last) begin
            state_n = DRAIN;
          end else begin
            elem_inc    = 1'b1;
            ag_load     = 1'b1;
            ag_load_dir = first_dir(algo_q, elem_q + 3'd1);
          end
        end
      end
      // Two drain cycles: one for the SRAM read latency, one to commit the compare.
      DRAIN: begin
        if (abort)        state_n = IDLE;
        else if (drain_q) state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      algo_q  <= MARCH_CM;
      elem_q  <= '0;
      op_q    <= 1'b0;
      drain_q <= 1'b0;
    end else begin
      drain_q <= (state == DRAIN);
      if (launch) begin
        algo_q <= algo_e'(algo_sel);
        elem_q <= '0;
        op_q   <= 1'b0;
      end else begin
        if (elem_inc) elem_q <= elem_q + 3'd1;
        if (op_set)      op_q <= 1'b1;
        else if (op_clr) op_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (launch) bg_q <= bg;
  end

  // Stage p1: expectation registered with each issued read
  always_ff @(posedge clk) begin
    if (run && !cur_is_write) begin
      exp_p1  <= pattern;
      addr_p1 <= addr;
      elem_p1 <= elem_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= run && !cur_is_write && !abort;
  end

  // Stage p2: compare returning read data, count and capture first failure
  assign mismatch = vld_p1 && !abort_hit && (mem_rdata != exp_p1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_addr <= '0;
      fail_elem <= '0;
      fail_syn  <= '0;
      fail_cnt  <= '0;
    end else if (launch) begin
      fail_addr <= '0;
      fail_elem <= '0;
      fail_syn  <= '0;
      fail_cnt  <= '0;
    end else if (mismatch) begin
      fail_cnt <= sat_inc(fail_cnt);
      if (fail_cnt == '0) begin
        fail_addr <= addr_p1;
        fail_elem <= elem_p1;
        fail_syn  <= exp_p1 ^ mem_rdata;
      end
    end
  end

  assign test_mode = busy;
  assign mem_en    = run;
  assign mem_we    = run && cur_is_write;
  assign mem_addr  = run ? addr : '0;
  assign mem_wdata = (run && cur_is_write) ? pattern : '0;
  assign done      = (state == DONE);
  assign pass      = done && (fail_cnt == '0);

endmodule

// File: tb/tb_mbist_march_engine.sv
// Directed bench for mbist_march_engine with a behavioural SRAM, fault injection
// and a scoreboard of the expected op/address/data trace.
module tb_mbist_march_engine;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int CW = 4;
  localparam int N  = 16;

  logic          clk = 1'b0;
  logic          rst, start, abort, algo_sel;
  logic [DW-1:0] bg, mem_rdata;
  logic          test_mode, mem_en, mem_we, busy, done, pass;
  logic [AW-1:0] mem_addr, fail_addr;
  logic [DW-1:0] mem_wdata, fail_syn;
  logic [2:0]    fail_elem;
  logic [CW-1:0] fail_cnt;
  logic [36:0]   outs;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } op_t;

  op_t   exp_q[$];
  op_t   mon_obs, mon_exp;
  logic  mon_have;
  int    tests = 0;
  int    fails = 0;
  int    fault_mode = 0;
  logic [DW-1:0] sram [N];

  always #5 clk = ~clk;

  assign outs = {test_mode, mem_en, mem_we, mem_addr, mem_wdata, busy, done, pass,
                 fail_addr, fail_elem, fail_syn, fail_cnt};

  mbist_march_engine #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .algo_sel  (algo_sel),
    .bg        (bg),
    .mem_rdata (mem_rdata),
    .test_mode (test_mode),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_addr (fail_addr),
    .fail_elem (fail_elem),
    .fail_syn  (fail_syn),
    .fail_cnt  (fail_cnt)
  );

  function automatic logic [DW-1:0] fault_rd(input logic [DW-1:0] v, input logic [AW-1:0] a);
    case (fault_mode)
      1:       return (a == 4'h5) ? (v | 8'h01) : v;
      2:       return ~v;
      default: return v;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (mem_en && mem_we)  sram[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= fault_rd(sram[mem_addr], mem_addr);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected trace: codes 0=w0 1=w1 2=r0 3=r1; read data field is don't-care (0).
  task automatic push_trace(input logic a, input logic [DW-1:0] d);
    int ne, nops, c0, c1, code;
    logic dn;
    logic [AW-1:0] ad;
    op_t o;
    ne = a ? 3 : 6;
    for (int e = 0; e < ne; e++) begin
      dn = 1'b0; nops = 2; c0 = 2; c1 = 1;
      if (!a) begin
        case (e)
          0: begin nops = 1; c0 = 0; end
          1: begin c0 = 2; c1 = 1; end
          2: begin c0 = 3; c1 = 0; end
          3: begin dn = 1'b1; c0 = 2; c1 = 1; end
          4: begin dn = 1'b1; c0 = 3; c1 = 0; end
          default: begin nops = 1; c0 = 2; end
        endcase
      end else begin
        case (e)
          0: begin nops = 1; c0 = 0; end
          1: begin c0 = 2; c1 = 1; end
          default: begin dn = 1'b1; c0 = 3; c1 = 0; end
        endcase
      end
      for (int i = 0; i < N; i++) begin
        ad = dn ? AW'(N - 1 - i) : AW'(i);
        for (int j = 0; j < nops; j++) begin
          code    = (j == 0) ? c0 : c1;
          o.we    = (code < 2);
          o.addr  = ad;
          o.wdata = (code == 0) ? d : (code == 1) ? ~d : '0;
          exp_q.push_back(o);
        end
      end
    end
  endtask

  task automatic launch(input logic a, input logic [DW-1:0] d);
    @(negedge clk);
    algo_sel = a; bg = d; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (mem_en === 1'b1) begin
      mon_obs  = {mem_we, mem_addr, mem_we ? mem_wdata : 8'h00};
      mon_have = (exp_q.size() != 0);
      mon_exp  = mon_have ? exp_q.pop_front() : '0;
      check("op_trace", {1'b1, mon_obs}, {mon_have, mon_exp});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; abort = 1'b0; algo_sel = 1'b0; bg = '0;
    #7;
    check("reset_outputs", outs, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // March C- fault-free
    push_trace(1'b0, 8'h00);
    launch(1'b0, 8'h00);
    check("t1_busy_after_start", {busy, test_mode, done}, 3'b110);
    wait_done(n);
    check("t1_done_latency", n, 162);
    check("t1_pass", {pass, test_mode, busy}, 3'b100);
    check("t1_fail_cnt", fail_cnt, 0);
    check("t1_trace_left", exp_q.size(), 0);

    // Stuck-at-1 bit0 at address 5
    fault_mode = 1;
    push_trace(1'b0, 8'h00);
    launch(1'b0, 8'h00);
    wait_done(n);
    check("t2_done_latency", n, 162);
    check("t2_pass", pass, 0);
    check("t2_fail_addr", fail_addr, 4'h5);
    check("t2_fail_elem", fail_elem, 3'd1);
    check("t2_fail_syn", fail_syn, 8'h01);
    check("t2_fail_cnt", fail_cnt, 4'd3);
    fault_mode = 0;

    // MATS+ with background 0xA5
    push_trace(1'b1, 8'hA5);
    launch(1'b1, 8'hA5);
    check("t3_cleared_on_start", {fail_addr, fail_elem, fail_syn, fail_cnt}, 0);
    check("t3_first_write", {mem_en, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 4'h0, 8'hA5});
    wait_done(n);
    check("t3_done_latency", n, 82);
    check("t3_pass", pass, 1);
    check("t3_trace_left", exp_q.size(), 0);

    // Abort at RUN cycle 20, then clean re-run
    push_trace(1'b0, 8'h3C);
    launch(1'b0, 8'h3C);
    repeat (19) @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    check("t4_abort_stops", {busy, mem_en, test_mode, done}, 4'b0000);
    abort = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("t4_no_done_after_abort", {done, busy, mem_en}, 3'b000);
    check("t4_ops_before_abort", exp_q.size(), 160 - 20);
    exp_q.delete();
    push_trace(1'b1, 8'h3C);
    launch(1'b1, 8'h3C);
    wait_done(n);
    check("t4_rerun_latency", n, 82);
    check("t4_rerun_pass", pass, 1);

    // Async reset mid-element and mid-DRAIN
    push_trace(1'b0, 8'h00);
    launch(1'b0, 8'h00);
    repeat (37) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("t5_rst_mid_elem", outs, 0);
    repeat (2) @(negedge clk);
    exp_q.delete();
    rst = 1'b0;
    push_trace(1'b1, 8'h00);
    launch(1'b1, 8'h00);
    repeat (80) @(posedge clk);
    #1;
    check("t5_in_drain", {busy, mem_en, done}, 3'b100);
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_mid_drain", outs, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("t5_trace_left", exp_q.size(), 0);
    push_trace(1'b1, 8'h0F);
    launch(1'b1, 8'h0F);
    wait_done(n);
    check("t5_full_run_latency", n, 82);
    check("t5_full_run_pass", pass, 1);

    // Fault at every address: counter saturates; start held in DONE clears it
    fault_mode = 2;
    push_trace(1'b1, 8'h00);
    launch(1'b1, 8'h00);
    wait_done(n);
    check("t6_done_latency", n, 82);
    check("t6_fail_cnt_sat", fail_cnt, 4'hF);
    check("t6_pass", pass, 0);
    check("t6_first_fail", {fail_addr, fail_elem, fail_syn}, {4'h0, 3'd1, 8'hFF});
    fault_mode = 0;
    push_trace(1'b1, 8'h00);
    @(negedge clk);
    algo_sel = 1'b1; bg = 8'h00; start = 1'b1;
    @(posedge clk);
    #1;
    check("t6_restart_clears", {fail_cnt, busy, done}, {4'h0, 1'b1, 1'b0});
    repeat (5) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    check("t6_latency_start_held", n + 5, 82);
    check("t6_rerun_pass", {pass, fail_cnt}, {1'b1, 4'h0});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
